mux16_rr_arbiter: RTL and testbench
===================================

MUX16_RR_ARBITER -- requirements
Module: mux16_rr_arbiter

Interface
REQ-001 The module SHALL have parameter HOLD_MAX, default 16, giving the maximum GRANT-state cycles before a forced release (used only when MUX16_ARB_TIMEOUT_EN is defined).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The module SHALL have port req, input, 16, per-requester request; bit i requests mux input i.
REQ-005 The module SHALL have port done, input, 1, the current owner's end-of-use pulse.
REQ-006 The module SHALL have port sel, output, 4, the select driven to the mux16to1 sel input.
REQ-007 The module SHALL have port gnt, output, 16, the one-hot grant; bit i set means requester i owns the mux.
REQ-008 The module SHALL have port busy, output, 1, high while in GRANT.
REQ-009 The module SHALL have port timeout, output, 1, a one-cycle pulse on forced release.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT and RELEASE, with every output registered.
REQ-011 In IDLE with req != 0, the arbiter SHALL pick the first set req bit scanning upward from pointer ptr (4-bit, wrapping 15->0), and on the next edge SHALL enter GRANT with gnt = one-hot(index), sel = index, busy = 1.
REQ-012 The req-to-gnt latency SHALL be exactly 1 clock; in IDLE with req == 0 the arbiter SHALL stay in IDLE.
REQ-013 In GRANT, gnt, sel and the owner SHALL hold constant; changes on other req bits SHALL be ignored.
REQ-014 GRANT SHALL exit to RELEASE on done = 1 or on req[sel] = 0 (owner withdraws), whichever comes first.
REQ-015 On the GRANT->RELEASE edge, ptr SHALL be set to sel+1 mod 16 (owner 15 -> ptr 0).
REQ-016 In RELEASE, gnt and busy SHALL be 0 for exactly one cycle, after which the state SHALL be IDLE. Back-to-back grants are therefore spaced by at least 2 idle cycles.
REQ-017 sel SHALL retain the last granted index in IDLE and RELEASE; it SHALL never glitch or change outside the IDLE->GRANT edge.
REQ-018 done SHALL be ignored in IDLE and RELEASE.
REQ-019 gnt SHALL always be either zero or one-hot, and SHALL equal one-hot(sel) whenever busy = 1.

Reset
REQ-020 When rst = 1 at a clock edge, the arbiter SHALL return to IDLE with sel = 0, gnt = 0, busy = 0, timeout = 0, ptr = 0 and the hold counter = 0, regardless of state.
REQ-021 rst SHALL take priority over done, req and the timeout, including a reset asserted mid-GRANT, which drops gnt on the same edge.
REQ-022 The first grant after reset SHALL favour the lowest set req bit.

Configuration
REQ-023 With macro MUX16_ARB_TIMEOUT_EN defined, a counter SHALL clear on GRANT entry and increment each GRANT cycle.
REQ-024 When that counter reaches HOLD_MAX-1 without done or withdrawal, the arbiter SHALL go to RELEASE with timeout = 1 for that one cycle, and ptr SHALL advance per REQ-015.
REQ-025 If done or withdrawal coincides with the terminal count, release SHALL be normal with timeout = 0.
REQ-026 Without MUX16_ARB_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied 0, and a grant SHALL be held indefinitely until done or withdrawal.

Verification
REQ-027 Reset then req=16'h0000 for 10 cycles -> gnt=0, busy=0, sel=0 throughout.
REQ-028 After reset, req=16'h8421 held, done pulsed 2 cycles after each grant -> grants in order sel=0,5,10,15,0; each gnt appears 1 cycle after IDLE.
REQ-029 After reset, owner sel=15 granted from req=16'h8001, done pulsed -> ptr wraps and the next grant is sel=0.
REQ-030 In GRANT with sel=3, req[3] deasserted -> RELEASE next edge, gnt=0 for 1 cycle, ptr=4.
REQ-031 rst asserted on the 3rd GRANT cycle with sel=7 -> next edge gnt=0, sel=0, busy=0; after release, req=16'h0080 is re-granted with sel=7.
REQ-032 With MUX16_ARB_TIMEOUT_EN defined and HOLD_MAX=4, req=16'h0002 held and done never asserted -> busy high 4 cycles, then timeout=1 for 1 cycle, then regrant of sel=1 after IDLE; a second run with done asserted on the 4th cycle -> timeout stays 0.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin owner arbiter driving a 16:1 mux select
// Optional forced release after HOLD_MAX grant cycles: define MUX16_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module mux16_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic [15:0] gnt,
  output logic        busy,
  output logic        timeout
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0] state;
  logic [3:0] ptr;
  logic [3:0] pick_idx;
  logic [3:0] cand;
  logic       pick_found;
  logic       owner_off;
  logic       hold_expired;

  // First requester at or above ptr, wrapping 15 -> 0.
  always_comb begin
    pick_idx   = ptr;
    pick_found = 1'b0;
    cand       = ptr;
    for (int k = 0; k < 16; k++) begin
      cand = ptr + 4'(k);
      if (!pick_found && req[cand]) begin
        pick_idx   = cand;
        pick_found = 1'b1;
      end
    end
  end

  assign owner_off = done || !req[sel];

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

  logic [CNT_W-1:0] hold_cnt;
  logic             timeout_q;

  assign hold_expired = (hold_cnt == CNT_W'(HOLD_MAX - 1));
  assign timeout      = timeout_q;

  // Counter is cleared while idle so it always starts at zero on grant entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == S_GRANT) && !owner_off && hold_expired;
      if (state == S_GRANT)
        hold_cnt <= hold_cnt + CNT_W'(1);
      else
        hold_cnt <= '0;
    end
  end
`else
  logic unused_hold_max;

  assign unused_hold_max = (HOLD_MAX != 0);
  assign hold_expired    = 1'b0;
  assign timeout         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      sel   <= 4'd0;
      gnt   <= 16'd0;
      busy  <= 1'b0;
      ptr   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state <= S_GRANT;
            sel   <= pick_idx;
            gnt   <= 16'd1 << pick_idx;
            busy  <= 1'b1;
          end
        end
        S_GRANT: begin
          if (owner_off || hold_expired) begin
            state <= S_RELEASE;
            gnt   <= 16'd0;
            busy  <= 1'b0;
            ptr   <= sel + 4'd1;
          end
        end
        S_RELEASE: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - scoreboard bench for mux16_rr_arbiter
`timescale 1ns/1ps
module tb_mux16_rr_arbiter;

  localparam int HOLD = 4;
`ifdef MUX16_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = 16'd0;
  logic        done = 1'b0;
  logic [3:0]  sel;
  logic [15:0] gnt;
  logic        busy;
  logic        timeout;

  mux16_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .gnt     (gnt),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        busy;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: who owns the mux, whether we sit in the release gap,
  // whom to favour next, and how many cycles the owner has held the grant.
  int m_owner = -1;
  bit m_gap   = 1'b0;
  int m_next  = 0;
  int m_sel   = 0;
  int m_age   = 0;
  bit m_to    = 1'b0;

  task automatic model_edge(input logic [15:0] r, input logic d, input logic rs);
    bit found;
    m_to = 1'b0;
    if (rs) begin
      m_owner = -1; m_gap = 1'b0; m_next = 0; m_sel = 0; m_age = 0;
    end else if (m_owner >= 0) begin
      if (d || !r[m_owner]) begin
        m_next = (m_owner + 1) % 16; m_owner = -1; m_gap = 1'b1;
      end else if (TO_EN && m_age == HOLD) begin
        m_next = (m_owner + 1) % 16; m_owner = -1; m_gap = 1'b1; m_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (m_gap) begin
      m_gap = 1'b0;
    end else if (r != 16'd0) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        if (!found && r[(m_next + k) % 16]) begin
          m_owner = (m_next + k) % 16;
          found = 1'b1;
        end
      end
      m_sel = m_owner;
      m_age = 1;
    end
  endtask

  task automatic step(input logic [15:0] r, input logic d, input logic rs);
    exp_t e;
    req = r; done = d; rst = rs;
    model_edge(r, d, rs);
    e.sel     = 4'(m_sel);
    e.gnt     = (m_owner >= 0) ? (16'd1 << m_owner) : 16'd0;
    e.busy    = (m_owner >= 0);
    e.timeout = m_to;
    @(posedge clk);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: pops one expectation per clocked output update.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (sel !== e.sel || gnt !== e.gnt || busy !== e.busy || timeout !== e.timeout) begin
          errors++;
          $display("FAIL outputs t=%0t: got sel=%0d gnt=%h busy=%b timeout=%b, expected sel=%0d gnt=%h busy=%b timeout=%b",
                   $time, sel, gnt, busy, timeout, e.sel, e.gnt, e.busy, e.timeout);
        end
        checks++;
        if (!(gnt == 16'd0 || ($onehot(gnt) && busy && gnt == (16'd1 << sel)))) begin
          errors++;
          $display("FAIL grant_shape t=%0t: got gnt=%h sel=%0d busy=%b, expected zero or one-hot(sel) with busy",
                   $time, gnt, sel, busy);
        end
      end
    end
  end

  initial begin
    logic [15:0] r;
    logic        d;
    logic        rs;

    step(16'h0000, 1'b0, 1'b1);
    step(16'h0000, 1'b0, 1'b1);
    repeat (10) step(16'h0000, 1'b0, 1'b0);

    // Rotating grants over 0,5,10,15,0
    step(16'h0000, 1'b0, 1'b1);
    repeat (5) begin
      step(16'h8421, 1'b0, 1'b0);
      step(16'h8421, 1'b0, 1'b0);
      step(16'h8421, 1'b1, 1'b0);
      step(16'h8421, 1'b0, 1'b0);
    end

    // Pointer wrap after owner 15
    step(16'h0000, 1'b0, 1'b1);
    repeat (3) begin
      step(16'h8001, 1'b0, 1'b0);
      step(16'h8001, 1'b1, 1'b0);
      step(16'h8001, 1'b0, 1'b0);
    end

    // Owner 3 withdraws; pointer moves to 4
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0008, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0018, 1'b0, 1'b0);
    step(16'h0018, 1'b0, 1'b0);
    step(16'h0018, 1'b1, 1'b0);
    step(16'h0018, 1'b0, 1'b0);

    // Reset on third grant cycle of owner 7
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b0, 1'b1);
    step(16'h0080, 1'b0, 1'b0);
    step(16'h0080, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);

    // Held grant: forced release when the timeout is built in
    step(16'h0000, 1'b0, 1'b1);
    repeat (8) step(16'h0002, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b1);
    step(16'h0002, 1'b0, 1'b0);
    repeat (3) step(16'h0002, 1'b0, 1'b0);
    step(16'h0002, 1'b1, 1'b0);
    step(16'h0000, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 1'b0);

    r = 16'h0000;
    repeat (3000) begin
      if ($urandom_range(3) == 0)
        r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      d  = ($urandom_range(5) == 0);
      rs = ($urandom_range(96) == 0);
      step(r, d, rs);
    end

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
